// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared datapath widths, ALU opcode encoding, forward-select encoding, the
// ID/EX stage register layout and a writeback-hit helper used by the
// operand-forwarding logic.
// ----------------------------------------------------------------------------
package cpu_pkg;

  localparam int DW = 32;  // datapath width
  localparam int AW = 5;   // register-address width
  localparam int CW = 5;   // ALU control width

  typedef enum logic [CW-1:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,
    ALU_NOR  = 5'd5,
    ALU_SLL  = 5'd6,
    ALU_SRL  = 5'd7,
    ALU_SRA  = 5'd8,
    ALU_SLT  = 5'd9,
    ALU_BNE  = 5'd10,
    ALU_BLEZ = 5'd11,
    ALU_BGTZ = 5'd12,
    ALU_BLTZ = 5'd13
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  // Contents of the ID/EX pipeline register.
  typedef struct packed {
    logic          valid;
    logic          mem_read;
    logic          mem_write;
    logic          reg_write;
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic [AW-1:0] dst;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [15:0]   imm16;
    logic [4:0]    shamt;
    logic          ext_op;
    logic          lu_op;
    logic          alu_src1;
    logic          alu_src2;
    logic [CW-1:0] alu_ctrl;
    logic          sign;
  } ex_stage_t;

  // A later stage writes the register being read; $0 is hardwired and
  // never matches.
  function automatic logic wb_hit(input logic          we,
                                  input logic [AW-1:0] dst,
                                  input logic [AW-1:0] addr);
    return we && (dst != '0) && (dst == addr);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ----------------------------------------------------------------------------
// id_ex_stage_if
// Bundles every non-clock/reset signal of the ID/EX stage.
//   slave  : the stage itself (consumes ID, control and forwarding inputs,
//            drives ALU operands, registered control and the stall flag).
//   master : the surrounding pipeline / testbench.
// ----------------------------------------------------------------------------
interface id_ex_stage_if;
  import cpu_pkg::*;

  // Pipeline control
  logic          hold;
  logic          flush;
  // Decoded ID-stage instruction
  logic          id_valid;
  logic [AW-1:0] id_rs_addr;
  logic [AW-1:0] id_rt_addr;
  logic [AW-1:0] id_dst;
  logic          id_uses_rs;
  logic          id_uses_rt;
  logic [DW-1:0] id_rs_data;
  logic [DW-1:0] id_rt_data;
  logic [15:0]   id_imm16;
  logic [4:0]    id_shamt;
  logic          id_ext_op;
  logic          id_lu_op;
  logic          id_alu_src1;
  logic          id_alu_src2;
  logic [CW-1:0] id_alu_ctrl;
  logic          id_sign;
  logic          id_mem_read;
  logic          id_mem_write;
  logic          id_reg_write;
  // Forwarding sources
  logic          exmem_reg_write;
  logic [AW-1:0] exmem_dst;
  logic [DW-1:0] exmem_result;
  logic          memwb_reg_write;
  logic [AW-1:0] memwb_dst;
  logic [DW-1:0] memwb_data;
  // EX-side outputs
  logic [DW-1:0] alu_in1;
  logic [DW-1:0] alu_in2;
  logic [CW-1:0] alu_ctrl;
  logic          alu_sign;
  logic [DW-1:0] ex_store_data;
  logic [AW-1:0] ex_dst;
  logic          ex_valid;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic          ex_reg_write;
  logic          load_use_stall;

  modport slave (
    input  hold, flush,
    input  id_valid, id_rs_addr, id_rt_addr, id_dst, id_uses_rs, id_uses_rt,
    input  id_rs_data, id_rt_data, id_imm16, id_shamt, id_ext_op, id_lu_op,
    input  id_alu_src1, id_alu_src2, id_alu_ctrl, id_sign,
    input  id_mem_read, id_mem_write, id_reg_write,
    input  exmem_reg_write, exmem_dst, exmem_result,
    input  memwb_reg_write, memwb_dst, memwb_data,
    output alu_in1, alu_in2, alu_ctrl, alu_sign, ex_store_data, ex_dst,
    output ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, load_use_stall
  );

  modport master (
    output hold, flush,
    output id_valid, id_rs_addr, id_rt_addr, id_dst, id_uses_rs, id_uses_rt,
    output id_rs_data, id_rt_data, id_imm16, id_shamt, id_ext_op, id_lu_op,
    output id_alu_src1, id_alu_src2, id_alu_ctrl, id_sign,
    output id_mem_read, id_mem_write, id_reg_write,
    output exmem_reg_write, exmem_dst, exmem_result,
    output memwb_reg_write, memwb_dst, memwb_data,
    input  alu_in1, alu_in2, alu_ctrl, alu_sign, ex_store_data, ex_dst,
    input  ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, load_use_stall
  );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// ----------------------------------------------------------------------------
// fwd_mux
// Priority forwarding for one ALU source operand.
//   src_addr_i             : registered source register of the EX instruction
//   reg_data_i             : registered (capture-time) operand value
//   exmem_* / memwb_*      : in-flight results from later stages
//   data_o                 : forwarded operand (EX/MEM > MEM/WB > register)
// ----------------------------------------------------------------------------
module fwd_mux
  import cpu_pkg::*;
(
  input  logic [AW-1:0] src_addr_i,
  input  logic [DW-1:0] reg_data_i,
  input  logic          exmem_reg_write_i,
  input  logic [AW-1:0] exmem_dst_i,
  input  logic [DW-1:0] exmem_result_i,
  input  logic          memwb_reg_write_i,
  input  logic [AW-1:0] memwb_dst_i,
  input  logic [DW-1:0] memwb_data_i,
  output logic [DW-1:0] data_o
);

  fwd_sel_e sel;

  always_comb begin
    sel = FWD_NONE;
    // EX/MEM holds the younger result, so it wins over MEM/WB.
    if (wb_hit(exmem_reg_write_i, exmem_dst_i, src_addr_i)) begin
      sel = FWD_EXMEM;
    end else if (wb_hit(memwb_reg_write_i, memwb_dst_i, src_addr_i)) begin
      sel = FWD_MEMWB;
    end

    unique case (sel)
      FWD_EXMEM: data_o = exmem_result_i;
      FWD_MEMWB: data_o = memwb_data_i;
      default:   data_o = reg_data_i;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register plus EX operand preparation feeding the ALU.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   bus.slave  : ID inputs, hold/flush, forwarding sources in; ALU operands,
//                registered control, store data and load_use_stall out
// Operands are valid one cycle after capture; alu_in1/alu_in2/store data are
// combinational from the stage register and the live forwarding inputs.
// ----------------------------------------------------------------------------
module id_ex_stage
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  id_ex_stage_if.slave bus
);

  ex_stage_t     stage_q, stage_d;
  logic          load_use;
  logic [DW-1:0] fwd_rs, fwd_rt;
  logic [DW-1:0] ext_imm;

  // A load in EX cannot forward in time to a consumer still in ID. Not
  // masked by hold/flush; upstream combines them.
  assign load_use = stage_q.valid && stage_q.mem_read && (stage_q.dst != '0)
                 && bus.id_valid
                 && ((bus.id_uses_rs && (bus.id_rs_addr == stage_q.dst))
                  || (bus.id_uses_rt && (bus.id_rt_addr == stage_q.dst)));

  assign bus.load_use_stall = load_use;

  // Capture priority: hold > flush > load-use bubble > new instruction.
  always_comb begin
    // NOTE: start from the held value so every path assigns stage_d and no
    // latch is inferred.
    stage_d = stage_q;
    if (bus.hold) begin
      stage_d = stage_q;
    end else if (bus.flush || load_use) begin
      stage_d = '0;
    end else begin
      stage_d.valid     = bus.id_valid;
      // Control is qualified by id_valid so an empty ID slot behaves as a
      // bubble downstream.
      stage_d.mem_read  = bus.id_valid && bus.id_mem_read;
      stage_d.mem_write = bus.id_valid && bus.id_mem_write;
      stage_d.reg_write = bus.id_valid && bus.id_reg_write;
      stage_d.rs_addr   = bus.id_rs_addr;
      stage_d.rt_addr   = bus.id_rt_addr;
      stage_d.dst       = bus.id_dst;
      // Write-first register file: a same-cycle MEM/WB write overrides the
      // stale read data.
      stage_d.rs_data   = wb_hit(bus.memwb_reg_write, bus.memwb_dst, bus.id_rs_addr)
                          ? bus.memwb_data : bus.id_rs_data;
      stage_d.rt_data   = wb_hit(bus.memwb_reg_write, bus.memwb_dst, bus.id_rt_addr)
                          ? bus.memwb_data : bus.id_rt_data;
      stage_d.imm16     = bus.id_imm16;
      stage_d.shamt     = bus.id_shamt;
      stage_d.ext_op    = bus.id_ext_op;
      stage_d.lu_op     = bus.id_lu_op;
      stage_d.alu_src1  = bus.id_alu_src1;
      stage_d.alu_src2  = bus.id_alu_src2;
      stage_d.alu_ctrl  = bus.id_alu_ctrl;
      stage_d.sign      = bus.id_sign;
    end
  end

  // NOTE: the whole stage register is cleared on reset so a discarded
  // instruction cannot leak data fields into the ALU.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      stage_q <= stage_d;
    end
  end

  fwd_mux u_fwd_rs (
    .src_addr_i        (stage_q.rs_addr),
    .reg_data_i        (stage_q.rs_data),
    .exmem_reg_write_i (bus.exmem_reg_write),
    .exmem_dst_i       (bus.exmem_dst),
    .exmem_result_i    (bus.exmem_result),
    .memwb_reg_write_i (bus.memwb_reg_write),
    .memwb_dst_i       (bus.memwb_dst),
    .memwb_data_i      (bus.memwb_data),
    .data_o            (fwd_rs)
  );

  fwd_mux u_fwd_rt (
    .src_addr_i        (stage_q.rt_addr),
    .reg_data_i        (stage_q.rt_data),
    .exmem_reg_write_i (bus.exmem_reg_write),
    .exmem_dst_i       (bus.exmem_dst),
    .exmem_result_i    (bus.exmem_result),
    .memwb_reg_write_i (bus.memwb_reg_write),
    .memwb_dst_i       (bus.memwb_dst),
    .memwb_data_i      (bus.memwb_data),
    .data_o            (fwd_rt)
  );

  // LUI placement takes precedence over sign/zero extension.
  always_comb begin
    if (stage_q.lu_op) begin
      ext_imm = {stage_q.imm16, 16'b0};
    end else if (stage_q.ext_op) begin
      ext_imm = {{(DW-16){stage_q.imm16[15]}}, stage_q.imm16};
    end else begin
      ext_imm = {{(DW-16){1'b0}}, stage_q.imm16};
    end
  end

  assign bus.alu_in1       = stage_q.alu_src1 ? {{(DW-5){1'b0}}, stage_q.shamt} : fwd_rs;
  assign bus.alu_in2       = stage_q.alu_src2 ? ext_imm : fwd_rt;
  assign bus.ex_store_data = fwd_rt;
  assign bus.alu_ctrl      = stage_q.alu_ctrl;
  assign bus.alu_sign      = stage_q.sign;
  assign bus.ex_dst        = stage_q.dst;
  assign bus.ex_valid      = stage_q.valid;
  assign bus.ex_mem_read   = stage_q.mem_read;
  assign bus.ex_mem_write  = stage_q.mem_write;
  assign bus.ex_reg_write  = stage_q.reg_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage
// Directed stimulus for id_ex_stage. The stimulus process pushes the
// hand-computed outputs expected in the current cycle into a scoreboard
// queue; a monitor on the falling edge pops and compares them.
// ----------------------------------------------------------------------------
module tb_id_ex_stage;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    string       name;
    logic        v, mr, mw, rw, sg, stall;
    logic [4:0]  ctrl, dst;
    logic [31:0] in1, in2, st;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string nm, input string fld,
                     input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, want);
    end
  endtask

  // Monitor: compare whatever the scoreboard expects for this cycle.
  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() != 0 && sb_q[0].cyc < cyc) begin
      e = sb_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s.missed: got no sample expected cycle %0d", e.name, e.cyc);
    end
    if (sb_q.size() != 0 && sb_q[0].cyc == cyc) begin
      e = sb_q.pop_front();
      chk(e.name, "ex_valid",  {31'b0, bus.ex_valid},       {31'b0, e.v});
      chk(e.name, "mem_read",  {31'b0, bus.ex_mem_read},    {31'b0, e.mr});
      chk(e.name, "mem_write", {31'b0, bus.ex_mem_write},   {31'b0, e.mw});
      chk(e.name, "reg_write", {31'b0, bus.ex_reg_write},   {31'b0, e.rw});
      chk(e.name, "alu_ctrl",  {27'b0, bus.alu_ctrl},       {27'b0, e.ctrl});
      chk(e.name, "alu_sign",  {31'b0, bus.alu_sign},       {31'b0, e.sg});
      chk(e.name, "ex_dst",    {27'b0, bus.ex_dst},         {27'b0, e.dst});
      chk(e.name, "alu_in1",   bus.alu_in1,                 e.in1);
      chk(e.name, "alu_in2",   bus.alu_in2,                 e.in2);
      chk(e.name, "store",     bus.ex_store_data,           e.st);
      chk(e.name, "stall",     {31'b0, bus.load_use_stall}, {31'b0, e.stall});
    end
  end

  task automatic expect_out(input string nm, input logic v, input logic mr,
                            input logic mw, input logic rw, input logic [4:0] ctrl,
                            input logic sg, input logic [4:0] dst,
                            input logic [31:0] in1, input logic [31:0] in2,
                            input logic [31:0] st, input logic stall);
    exp_t e;
    e.cyc = cyc; e.name = nm;
    e.v = v; e.mr = mr; e.mw = mw; e.rw = rw; e.ctrl = ctrl; e.sg = sg;
    e.dst = dst; e.in1 = in1; e.in2 = in2; e.st = st; e.stall = stall;
    sb_q.push_back(e);
  endtask

  task automatic expect_zero(input string nm);
    expect_out(nm, 0, 0, 0, 0, 5'd0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic id_clear();
    bus.id_valid = 0;     bus.id_rs_addr = '0;  bus.id_rt_addr = '0;
    bus.id_dst = '0;      bus.id_uses_rs = 0;   bus.id_uses_rt = 0;
    bus.id_rs_data = '0;  bus.id_rt_data = '0;  bus.id_imm16 = '0;
    bus.id_shamt = '0;    bus.id_ext_op = 0;    bus.id_lu_op = 0;
    bus.id_alu_src1 = 0;  bus.id_alu_src2 = 0;  bus.id_alu_ctrl = '0;
    bus.id_sign = 0;      bus.id_mem_read = 0;  bus.id_mem_write = 0;
    bus.id_reg_write = 0;
  endtask

  task automatic fwd_clear();
    bus.exmem_reg_write = 0; bus.exmem_dst = '0; bus.exmem_result = '0;
    bus.memwb_reg_write = 0; bus.memwb_dst = '0; bus.memwb_data = '0;
  endtask

  task automatic fwd_set(input logic ew, input logic [4:0] ed, input logic [31:0] er,
                         input logic mw, input logic [4:0] md, input logic [31:0] mdat);
    bus.exmem_reg_write = ew; bus.exmem_dst = ed; bus.exmem_result = er;
    bus.memwb_reg_write = mw; bus.memwb_dst = md; bus.memwb_data = mdat;
  endtask

  initial begin
    // Reset held while ID presents a live instruction.
    reset = 1; bus.hold = 0; bus.flush = 0;
    id_clear(); fwd_clear();
    bus.id_valid = 1; bus.id_reg_write = 1; bus.id_dst = 5'd3; bus.id_rs_data = 32'h11;

    step(); expect_zero("rst_on");
    // Release: nothing is captured until the next edge.
    step(); reset = 0; expect_zero("rst_off");
    // ADDI $9, $8, -1
    id_clear(); bus.id_valid = 1; bus.id_rs_addr = 5'd8; bus.id_uses_rs = 1;
    bus.id_rs_data = 32'h10; bus.id_rt_addr = 5'd9; bus.id_rt_data = 32'h3;
    bus.id_dst = 5'd9; bus.id_imm16 = 16'hFFFF; bus.id_ext_op = 1; bus.id_alu_src2 = 1;
    bus.id_alu_ctrl = ALU_ADD; bus.id_reg_write = 1;

    step(); expect_out("addi", 1, 0, 0, 1, ALU_ADD, 0, 5'd9, 32'h10, 32'hFFFF_FFFF, 32'h3, 0);
    // ADD $11, $8, $10
    id_clear(); bus.id_valid = 1; bus.id_rs_addr = 5'd8; bus.id_rt_addr = 5'd10;
    bus.id_uses_rs = 1; bus.id_uses_rt = 1; bus.id_rs_data = 32'h10; bus.id_rt_data = 32'h20;
    bus.id_dst = 5'd11; bus.id_reg_write = 1; bus.id_alu_ctrl = ALU_ADD;

    // Both later stages write $8: EX/MEM wins.
    step(); fwd_set(1, 5'd8, 32'h55, 1, 5'd8, 32'h77);
    expect_out("fwd_pri", 1, 0, 0, 1, ALU_ADD, 0, 5'd11, 32'h55, 32'h20, 32'h20, 0);
    // SUB $12, $0, $0 with nonzero regfile data to expose any $0 forwarding
    id_clear(); bus.id_valid = 1; bus.id_uses_rs = 1; bus.id_uses_rt = 1;
    bus.id_rs_data = 32'h13; bus.id_rt_data = 32'h14; bus.id_dst = 5'd12;
    bus.id_reg_write = 1; bus.id_alu_ctrl = ALU_SUB;

    step(); fwd_set(1, 5'd0, 32'h55, 1, 5'd0, 32'h77);
    expect_out("fwd_r0", 1, 0, 0, 1, ALU_SUB, 0, 5'd12, 32'h13, 32'h14, 32'h14, 0);
    // LW $9, 4($8)
    id_clear(); bus.id_valid = 1; bus.id_rs_addr = 5'd8; bus.id_uses_rs = 1;
    bus.id_rs_data = 32'h100; bus.id_rt_addr = 5'd9; bus.id_rt_data = 32'h5;
    bus.id_dst = 5'd9; bus.id_imm16 = 16'h0004; bus.id_ext_op = 1; bus.id_alu_src2 = 1;
    bus.id_mem_read = 1; bus.id_reg_write = 1; bus.id_alu_ctrl = ALU_ADD;

    // Load in EX, consumer of $9 in ID: stall this cycle.
    step(); fwd_clear();
    expect_out("lw", 1, 1, 0, 1, ALU_ADD, 0, 5'd9, 32'h100, 32'h4, 32'h5, 1);
    id_clear(); bus.id_valid = 1; bus.id_rs_addr = 5'd10; bus.id_uses_rs = 1;
    bus.id_rs_data = 32'h1; bus.id_rt_addr = 5'd9; bus.id_uses_rt = 1;
    bus.id_rt_data = 32'h2; bus.id_dst = 5'd12; bus.id_reg_write = 1; bus.id_alu_ctrl = ALU_ADD;

    // Bubble; load data now arrives on MEM/WB and is bypassed at capture.
    step(); fwd_set(0, 5'd0, 32'h0, 1, 5'd9, 32'hABCD);
    expect_zero("lu_bubble");

    // Retried consumer: rt from capture bypass; rs via EX-side MEM/WB path
    // (EX/MEM matches but is not writing).
    step(); fwd_set(0, 5'd10, 32'h55, 1, 5'd10, 32'h99);
    expect_out("lu_retry", 1, 0, 0, 1, ALU_ADD, 0, 5'd12, 32'h99, 32'hABCD, 32'hABCD, 0);
    // SLL $13, $11, 4
    id_clear(); bus.id_valid = 1; bus.id_rt_addr = 5'd11; bus.id_uses_rt = 1;
    bus.id_rt_data = 32'h8; bus.id_dst = 5'd13; bus.id_shamt = 5'd4; bus.id_alu_src1 = 1;
    bus.id_alu_ctrl = ALU_SLL; bus.id_reg_write = 1;

    step(); fwd_clear();
    expect_out("sll", 1, 0, 0, 1, ALU_SLL, 0, 5'd13, 32'h4, 32'h8, 32'h8, 0);
    // LUI $14, 0x1234 (ext_op set to show LUI has precedence)
    id_clear(); bus.id_valid = 1; bus.id_rt_addr = 5'd14; bus.id_rt_data = 32'h7;
    bus.id_dst = 5'd14; bus.id_imm16 = 16'h1234; bus.id_lu_op = 1; bus.id_ext_op = 1;
    bus.id_alu_src2 = 1; bus.id_alu_ctrl = ALU_ADD; bus.id_reg_write = 1;

    step(); expect_out("lui", 1, 0, 0, 1, ALU_ADD, 0, 5'd14, 32'h0, 32'h1234_0000, 32'h7, 0);
    // ORI $16, $15, 0x8001 (zero-extended)
    id_clear(); bus.id_valid = 1; bus.id_rs_addr = 5'd15; bus.id_uses_rs = 1;
    bus.id_rs_data = 32'h0F0F; bus.id_rt_addr = 5'd16; bus.id_rt_data = 32'h9;
    bus.id_dst = 5'd16; bus.id_imm16 = 16'h8001; bus.id_alu_src2 = 1;
    bus.id_alu_ctrl = ALU_OR; bus.id_reg_write = 1;

    step(); expect_out("ori", 1, 0, 0, 1, ALU_OR, 0, 5'd16, 32'h0F0F, 32'h0000_8001, 32'h9, 0);
    // SW $17, -8($16), signed flag set
    id_clear(); bus.id_valid = 1; bus.id_rs_addr = 5'd16; bus.id_uses_rs = 1;
    bus.id_rt_addr = 5'd17; bus.id_uses_rt = 1; bus.id_rs_data = 32'h200;
    bus.id_rt_data = 32'h30; bus.id_imm16 = 16'hFFF8; bus.id_ext_op = 1;
    bus.id_alu_src2 = 1; bus.id_mem_write = 1; bus.id_sign = 1; bus.id_alu_ctrl = ALU_ADD;

    // Store data forwarded from EX/MEM while in2 stays the immediate.
    step(); fwd_set(1, 5'd17, 32'hDEAD, 0, 5'd0, 32'h0);
    expect_out("sw", 1, 0, 1, 0, ALU_ADD, 1, 5'd0, 32'h200, 32'hFFFF_FFF8, 32'hDEAD, 0);
    id_clear(); bus.id_valid = 1; bus.id_rs_addr = 5'd1; bus.id_rs_data = 32'h44;
    bus.id_dst = 5'd2; bus.id_reg_write = 1; bus.id_alu_ctrl = ALU_XOR;
    bus.hold = 1; bus.flush = 1;

    // Hold beats flush for two edges.
    step(); expect_out("hold1", 1, 0, 1, 0, ALU_ADD, 1, 5'd0, 32'h200, 32'hFFFF_FFF8, 32'hDEAD, 0);
    step(); expect_out("hold2", 1, 0, 1, 0, ALU_ADD, 1, 5'd0, 32'h200, 32'hFFFF_FFF8, 32'hDEAD, 0);
    bus.hold = 0;

    // Flush still high once hold drops: bubble.
    step(); expect_zero("flush");
    bus.flush = 0; fwd_clear();
    // LW $18, 0($3)
    id_clear(); bus.id_valid = 1; bus.id_rs_addr = 5'd3; bus.id_uses_rs = 1;
    bus.id_rs_data = 32'h8; bus.id_rt_addr = 5'd18; bus.id_dst = 5'd18;
    bus.id_ext_op = 1; bus.id_alu_src2 = 1; bus.id_mem_read = 1; bus.id_reg_write = 1;
    bus.id_alu_ctrl = ALU_ADD;

    // Flush and load-use together: stall still visible.
    step(); bus.flush = 1;
    id_clear(); bus.id_valid = 1; bus.id_rs_addr = 5'd18; bus.id_uses_rs = 1;
    bus.id_rs_data = 32'h1; bus.id_dst = 5'd19; bus.id_reg_write = 1; bus.id_alu_ctrl = ALU_ADD;
    expect_out("lw2", 1, 1, 0, 1, ALU_ADD, 0, 5'd18, 32'h8, 32'h0, 32'h0, 1);

    step(); bus.flush = 0; expect_zero("flush_stall");

    step(); expect_out("n_cap", 1, 0, 0, 1, ALU_ADD, 0, 5'd19, 32'h1, 32'h0, 32'h0, 0);
    // AND $7, $5, $6
    id_clear(); bus.id_valid = 1; bus.id_rs_addr = 5'd5; bus.id_rs_data = 32'h66;
    bus.id_rt_addr = 5'd6; bus.id_rt_data = 32'h77; bus.id_dst = 5'd7;
    bus.id_reg_write = 1; bus.id_alu_ctrl = ALU_AND;

    // Captured instruction wiped by a mid-cycle asynchronous reset.
    step(); #1 reset = 1; expect_zero("rst_async");
    step(); reset = 0; expect_zero("rst_held");
    step(); expect_out("post_rst", 1, 0, 0, 1, ALU_AND, 0, 5'd7, 32'h66, 32'h77, 32'h77, 0);
    id_clear();
    step(); expect_zero("idle");

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
